csr_access_unit: RTL and testbench
==================================

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have parameter CSR_ADDR_W, default 12, CSR address width.
REQ-002 SHALL have parameter DATA_W, default 32, CSR data width.
REQ-003 SHALL have port clk  in  1  clock; all state changes on posedge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  access request present.
REQ-006 SHALL have port req_ready  out  1  unit accepts a request (high only in IDLE).
REQ-007 SHALL have port req_funct3  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-008 SHALL have port req_csr_addr  in  CSR_ADDR_W  target CSR.
REQ-009 SHALL have port req_rs1_data  in  DATA_W  rs1 operand.
REQ-010 SHALL have port req_rs1_idx  in  5  rs1 index / zimm field.
REQ-011 SHALL have port rsp_valid  out  1  response present.
REQ-012 SHALL have port rsp_ready  in  1  consumer takes response.
REQ-013 SHALL have port rsp_rd_data  out  DATA_W  old CSR value for rd.
REQ-014 SHALL have port rsp_illegal  out  1  illegal-instruction flag.
REQ-015 SHALL have ports csr_rd_addr out CSR_ADDR_W, csr_rd_data in DATA_W  register-file combinational read port.
REQ-016 SHALL have ports csr_write_en out 1, csr_wb_addr out CSR_ADDR_W, csr_wb_data out DATA_W  register-file write port.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> WRITE -> RESP -> IDLE.
REQ-018 IDLE: on req_valid&&req_ready latch funct3, addr, rs1_idx and operand (RW/RS/RC: req_rs1_data; I-forms: zero-extended req_rs1_idx); go READ.
REQ-019 IDLE: funct3 000 or 100 SHALL go directly to RESP with rsp_illegal=1, rsp_rd_data=0, no register-file access.
REQ-020 READ: csr_rd_addr SHALL equal latched addr; csr_rd_data captured as old value at end of cycle.
REQ-021 WRITE: new value RW=op, RS=old|op, RC=old&~op; csr_write_en=1 for exactly this one cycle if write required, csr_wb_addr=latched addr.
REQ-022 Write required SHALL be: RW/RWI always; RS/RC/RSI/RCI only if rs1_idx != 0.
REQ-023 Required write to read-only CSR (addr[11:10]==2'b11) SHALL be suppressed; response illegal, rsp_rd_data=0.
REQ-024 Read-only CSR with no write required SHALL be legal.
REQ-025 WRITE state SHALL always be traversed (fixed latency): accept at cycle N -> rsp_valid at N+3.
REQ-026 RESP: rsp_valid, rsp_rd_data, rsp_illegal held stable until rsp_ready; IDLE next cycle after handshake.
REQ-027 No new request accepted before the response handshake completes (one access outstanding).
REQ-028 csr_write_en SHALL be 0 in all states other than WRITE.

Reset
REQ-029 rst high at posedge SHALL force IDLE from any state, aborting any access in progress.
REQ-030 While rst is high, csr_write_en, rsp_valid, req_ready SHALL be 0; rsp_rd_data, rsp_illegal, csr_rd_addr, csr_wb_addr, csr_wb_data SHALL be 0 after reset.
REQ-031 Aborted access SHALL produce no register-file write and no response.

Configuration
REQ-032 Macro CSR_ACCESS_COUNT_EN defined: extra output access_count out 32, increments by 1 at each completed response handshake, wraps 0xFFFFFFFF->0, reset to 0.
REQ-033 Macro undefined: access_count port and counter absent; all other behaviour identical.

Structure
REQ-034 Shared package csr_pkg SHALL hold funct3 encodings, FSM state type and the read-only address test.
REQ-035 New-value computation SHALL be a combinational sub-module csr_alu (op, old, operand -> new value).

Verification
REQ-036 CSRRW addr 0x001, rs1_data 0xDEADBEEF, CSR=0x12345678 -> write 0xDEADBEEF at N+2, rsp_rd_data 0x12345678 at N+3.
REQ-037 CSRRS rs1_idx=0 on 0x002 -> csr_write_en never high, rsp_rd_data = current value, illegal 0.
REQ-038 CSRRCI zimm=0x05, CSR=0x0000000F -> write 0x0000000A; CSRRSI zimm=0x10 -> write 0x0000001F.
REQ-039 CSRRW to 0xC00 -> no write, rsp_illegal 1, rsp_rd_data 0; funct3 100 -> rsp_valid at N+1, illegal 1.
REQ-040 rsp_ready held low 5 cycles -> outputs stable, req_ready 0; rst asserted in WRITE -> no write, IDLE, no response.

Source files
------------

// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared definitions for the CSR access unit: funct3 op field
//               encodings, FSM state type and access-legality helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    // funct3 = {imm, op}: bit 2 selects the zimm operand, bits [1:0] the op
    localparam int        c_F3_IMM_BIT = 2;
    localparam logic [1:0] c_OP_NONE   = 2'b00;
    localparam logic [1:0] c_OP_RW     = 2'b01;
    localparam logic [1:0] c_OP_RS     = 2'b10;
    localparam logic [1:0] c_OP_RC     = 2'b11;

    typedef enum logic [1:0] {
        c_ST_IDLE  = 2'd0,
        c_ST_READ  = 2'd1,
        c_ST_WRITE = 2'd2,
        c_ST_RESP  = 2'd3
    } csr_state_t;

    // funct3 000 and 100 carry no CSR operation
    function automatic logic op_is_illegal(input logic [1:0] op);
        return op == c_OP_NONE;
    endfunction

    // RW forms always write; set/clear forms write only for a nonzero rs1/zimm
    function automatic logic write_required(input logic [1:0] op, input logic [4:0] rs1_idx);
        return (op == c_OP_RW) || (rs1_idx != 5'd0);
    endfunction

    // Address bits [11:10] == 2'b11 mark the read-only CSR space
    function automatic logic addr_is_read_only(input logic [1:0] addr_hi);
        return addr_hi == 2'b11;
    endfunction

endpackage : csr_pkg
`default_nettype wire

// File: rtl/csr_alu.sv
`default_nettype none
// ============================================================================
// Module      : csr_alu
// Description : Combinational new-value computation for CSR read-modify-write
//               (write, set bits, clear bits).
// Revision    : 1.0 - initial release
// ============================================================================
module csr_alu
    import csr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_operand,
    output logic [DATA_W-1:0] o_new_val
);

    always_comb begin
        o_new_val = i_old;
        case (i_op)
            c_OP_RW: o_new_val = i_operand;
            c_OP_RS: o_new_val = i_old | i_operand;
            c_OP_RC: o_new_val = i_old & ~i_operand;
            default: o_new_val = i_old;
        endcase
    end

endmodule : csr_alu
`default_nettype wire

// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_unit
// Description : Fixed-latency CSR read-modify-write sequencer between a
//               request/response handshake and a CSR register file.
//               Optional macro CSR_ACCESS_COUNT_EN adds the access_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int CSR_ADDR_W = 12,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [CSR_ADDR_W-1:0] req_csr_addr,
    input  logic [DATA_W-1:0]     req_rs1_data,
    input  logic [4:0]            req_rs1_idx,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rd_data,
    output logic                  rsp_illegal,
    output logic [CSR_ADDR_W-1:0] csr_rd_addr,
    input  logic [DATA_W-1:0]     csr_rd_data,
    output logic                  csr_write_en,
    output logic [CSR_ADDR_W-1:0] csr_wb_addr,
    output logic [DATA_W-1:0]     csr_wb_data
`ifdef CSR_ACCESS_COUNT_EN
    ,
    output logic [31:0]           access_count
`endif
);

    csr_state_t            r_state;
    logic [1:0]            r_op;
    logic [4:0]            r_idx;
    logic [CSR_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]     r_operand;
    logic [DATA_W-1:0]     r_old;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rd_data;
    logic                  r_rsp_illegal;
    logic                  r_write_en;
    logic [CSR_ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0]     r_wb_data;

    logic                  w_accept;
    logic                  w_write_req;
    logic                  w_read_only;
    logic                  w_suppressed;
    logic                  w_rsp_hs;
    logic [DATA_W-1:0]     w_req_operand;
    logic [DATA_W-1:0]     w_new_val;

    assign w_accept      = req_valid && r_req_ready;
    assign w_rsp_hs      = (r_state == c_ST_RESP) && r_rsp_valid && rsp_ready;
    assign w_write_req   = write_required(r_op, r_idx);
    assign w_read_only   = addr_is_read_only(r_addr[CSR_ADDR_W-1 -: 2]);
    assign w_suppressed  = w_write_req && w_read_only;
    assign w_req_operand = req_funct3[c_F3_IMM_BIT] ? {{(DATA_W-5){1'b0}}, req_rs1_idx}
                                                    : req_rs1_data;

    // New value is formed straight from the combinational read data so the
    // write-port registers are loaded on the same edge that captures the old value.
    csr_alu #(
        .DATA_W (DATA_W)
    ) u_csr_alu (
        .i_op      (r_op),
        .i_old     (csr_rd_data),
        .i_operand (r_operand),
        .o_new_val (w_new_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_op          <= c_OP_NONE;
            r_idx         <= '0;
            r_addr        <= '0;
            r_operand     <= '0;
            r_old         <= '0;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rd_data <= '0;
            r_rsp_illegal <= 1'b0;
            r_write_en    <= 1'b0;
            r_wb_addr     <= '0;
            r_wb_data     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_op        <= req_funct3[1:0];
                        r_idx       <= req_rs1_idx;
                        r_addr      <= req_csr_addr;
                        r_operand   <= w_req_operand;
                        if (op_is_illegal(req_funct3[1:0])) begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_rd_data <= '0;
                            r_rsp_illegal <= 1'b1;
                            r_state       <= c_ST_RESP;
                        end else begin
                            r_state <= c_ST_READ;
                        end
                    end
                end
                c_ST_READ: begin
                    r_old      <= csr_rd_data;
                    r_wb_addr  <= r_addr;
                    r_wb_data  <= w_new_val;
                    r_write_en <= w_write_req && !w_read_only;
                    r_state    <= c_ST_WRITE;
                end
                c_ST_WRITE: begin
                    r_write_en    <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_illegal <= w_suppressed;
                    r_rsp_rd_data <= w_suppressed ? '0 : r_old;
                    r_state       <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Handshake and write strobes drop as soon as rst rises, not one edge later,
    // so a reset landing in WRITE can never leak a register-file write.
    assign req_ready    = r_req_ready && !rst;
    assign rsp_valid    = r_rsp_valid && !rst;
    assign csr_write_en = r_write_en && !rst;

    assign rsp_rd_data  = r_rsp_rd_data;
    assign rsp_illegal  = r_rsp_illegal;
    assign csr_rd_addr  = r_addr;
    assign csr_wb_addr  = r_wb_addr;
    assign csr_wb_data  = r_wb_data;

`ifdef CSR_ACCESS_COUNT_EN
    logic [31:0] r_access_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_access_count <= '0;
        end else if (w_rsp_hs) begin
            r_access_count <= r_access_count + 32'd1;
        end
    end

    assign access_count = r_access_count;
`endif

endmodule : csr_access_unit
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_unit
// Description : Directed and randomized bench for csr_access_unit against a
//               4096-entry CSR file and an expected-value model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rs1_idx;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd_data;
    logic        rsp_illegal;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_write_en;
    logic [11:0] csr_wb_addr;
    logic [31:0] csr_wb_data;
`ifdef CSR_ACCESS_COUNT_EN
    logic [31:0] access_count;
`endif

    logic [31:0] rf    [0:4095];
    logic [31:0] model [0:4095];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          wr_cyc = 0;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    int          checks = 0;
    int          errors = 0;
    int          handshakes = 0;

    csr_access_unit #(
        .CSR_ADDR_W (12),
        .DATA_W     (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_csr_addr (req_csr_addr),
        .req_rs1_data (req_rs1_data),
        .req_rs1_idx  (req_rs1_idx),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rd_data  (rsp_rd_data),
        .rsp_illegal  (rsp_illegal),
        .csr_rd_addr  (csr_rd_addr),
        .csr_rd_data  (csr_rd_data),
        .csr_write_en (csr_write_en),
        .csr_wb_addr  (csr_wb_addr),
        .csr_wb_data  (csr_wb_data)
`ifdef CSR_ACCESS_COUNT_EN
        ,
        .access_count (access_count)
`endif
    );

    always #5 clk = ~clk;

    assign csr_rd_data = rf[csr_rd_addr];

    // CSR file: every write is logged with the edge index that took it
    always @(posedge clk) begin
        if (csr_write_en) begin
            rf[csr_wb_addr] <= csr_wb_data;
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_addr <= csr_wb_addr;
            wr_data <= csr_wb_data;
        end
        cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_csr(input logic [11:0] addr, input logic [31:0] val);
        rf[addr]    = val;
        model[addr] = val;
    endtask

    // One complete access: expected outcome derived from the CSR rules, then
    // issue, timing/data checks, optional response back-pressure, handshake.
    task automatic do_access(input logic [2:0] f3, input logic [11:0] addr,
                             input logic [31:0] data, input logic [4:0] idx, input int hold);
        logic [31:0] old_v, opnd, nv, exp_rd;
        logic        ill, wreq, ro, exp_wr;
        int          n, exp_lat, wc0, t;
        old_v = model[addr];
        opnd  = f3[2] ? {27'd0, idx} : data;
        wreq  = (f3[1:0] == 2'b01) || (idx != 5'd0);
        ro    = (addr[11:10] == 2'b11);
        case (f3[1:0])
            2'b01:   nv = opnd;
            2'b10:   nv = old_v | opnd;
            2'b11:   nv = old_v & ~opnd;
            default: nv = old_v;
        endcase
        if (f3[1:0] == 2'b00) begin
            ill = 1'b1; exp_rd = 32'd0; exp_wr = 1'b0; exp_lat = 1;
        end else if (ro && wreq) begin
            ill = 1'b1; exp_rd = 32'd0; exp_wr = 1'b0; exp_lat = 3;
        end else begin
            ill = 1'b0; exp_rd = old_v; exp_wr = wreq; exp_lat = 3;
            if (wreq) model[addr] = nv;
        end
        wc0 = wr_cnt;
        @(negedge clk);
        req_valid    = 1'b1;
        req_funct3   = f3;
        req_csr_addr = addr;
        req_rs1_data = data;
        req_rs1_idx  = idx;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        check("req_ready", {31'd0, req_ready}, 32'd1);
        n = cyc;
        @(negedge clk);
        req_valid    = 1'b0;
        req_funct3   = 3'($urandom);
        req_csr_addr = 12'($urandom);
        req_rs1_data = $urandom;
        req_rs1_idx  = 5'($urandom);
        t = 0;
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        check("rsp_latency", 32'(cyc - n), 32'(exp_lat));
        check("rsp_rd_data", rsp_rd_data, exp_rd);
        check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, ill});
        check("write_count", 32'(wr_cnt - wc0), {31'd0, exp_wr});
        if (exp_wr) begin
            check("write_cycle", 32'(wr_cyc - n), 32'd2);
            check("write_addr", {20'd0, wr_addr}, {20'd0, addr});
            check("write_data", wr_data, nv);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rd_data", rsp_rd_data, exp_rd);
            check("hold_illegal", {31'd0, rsp_illegal}, {31'd0, ill});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        handshakes++;
        check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
        check("csr_contents", rf[addr], model[addr]);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [11:0] a;
        logic [4:0]  idx;
        int          wc0, n, t;
        logic        seen_rsp;

        for (int i = 0; i < 4096; i++) begin
            rf[i]    = $urandom;
            model[i] = rf[i];
        end
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_funct3 = 3'd0; req_csr_addr = 12'd0; req_rs1_data = 32'd0; req_rs1_idx = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_write_en", {31'd0, csr_write_en}, 32'd0);
        check("rst_rd_data", rsp_rd_data, 32'd0);
        check("rst_illegal", {31'd0, rsp_illegal}, 32'd0);
        check("rst_rd_addr", {20'd0, csr_rd_addr}, 32'd0);
        check("rst_wb_addr", {20'd0, csr_wb_addr}, 32'd0);
        check("rst_wb_data", csr_wb_data, 32'd0);
        rst = 1'b0;

        // Directed cases
        set_csr(12'h001, 32'h12345678);
        do_access(3'b001, 12'h001, 32'hDEADBEEF, 5'd3, 0);
        do_access(3'b010, 12'h002, 32'hFFFFFFFF, 5'd0, 0);
        set_csr(12'h003, 32'h0000000F);
        do_access(3'b111, 12'h003, 32'h0, 5'h05, 0);
        check("csrrci_result", rf[12'h003], 32'h0000000A);
        set_csr(12'h003, 32'h0000000F);
        do_access(3'b110, 12'h003, 32'h0, 5'h10, 0);
        check("csrrsi_result", rf[12'h003], 32'h0000001F);
        do_access(3'b001, 12'hC00, 32'h55AA55AA, 5'd1, 0);
        do_access(3'b010, 12'hC01, 32'h1, 5'd0, 0);
        do_access(3'b100, 12'h005, 32'h1, 5'd1, 0);
        do_access(3'b000, 12'h006, 32'h1, 5'd1, 2);
        do_access(3'b011, 12'h007, $urandom, 5'd9, 5);

        // Reset landing in WRITE aborts the access with no write and no response
        set_csr(12'h010, 32'hCAFEF00D);
        wc0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h010;
        req_rs1_data = 32'h01234567; req_rs1_idx = 5'd2;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_write_en_in_write", {31'd0, csr_write_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_write_en_rst", {31'd0, csr_write_en}, 32'd0);
        check("abort_req_ready_rst", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_rsp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        check("abort_no_response", {31'd0, seen_rsp}, 32'd0);
        check("abort_no_write", 32'(wr_cnt - wc0), 32'd0);
        check("abort_csr_unchanged", rf[12'h010], 32'hCAFEF00D);
        check("abort_idle_ready", {31'd0, req_ready}, 32'd1);
`ifdef CSR_ACCESS_COUNT_EN
        handshakes = 0;
`endif

        // Randomized accesses over a small address pool that spans read-only space
        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom);
            a   = {2'($urandom), 6'd0, 4'($urandom)};
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            do_access(f3, a, $urandom, idx, $urandom_range(0, 3));
        end

        n = 0;
        for (int i = 0; i < 4096; i++) begin
            if (rf[i] !== model[i]) n++;
        end
        check("final_csr_mismatches", 32'(n), 32'd0);
`ifdef CSR_ACCESS_COUNT_EN
        check("access_count", access_count, 32'(handshakes));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_csr_access_unit
`default_nettype wire
